mem_port_arbiter: RTL and testbench

// - Shares the single-port unified BRAM between three requesters: instruction fetch (IF stage),

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF, MEM and debug requesters onto one single-port BRAM.
// Define ARB_AGING_EN to add age-based promotion of starved IF/DBG requesters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
`ifdef ARB_AGING_EN
  , parameter int unsigned AGE_LIMIT = 8
`endif
) (
  input  logic              fast_clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              if_ack,
  output logic              mem_ack,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;
  typedef enum logic [1:0] {P_MEM, P_IF, P_DBG} port_e;

  state_e             state_q;
  port_e              gnt_q;
  port_e              gnt_d;
  logic [CNT_W-1:0]   lat_cnt_q;
  logic               any_req_c;

`ifdef ARB_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] if_age_q;
  logic [AGE_W-1:0] dbg_age_q;
  logic             if_aged_c;
  logic             dbg_aged_c;

  assign if_aged_c  = (if_age_q >= AGE_W'(AGE_LIMIT));
  assign dbg_aged_c = (dbg_age_q >= AGE_W'(AGE_LIMIT));
`endif

  assign any_req_c = mem_req | if_req | dbg_req;

  // Winner selection: MEM > IF > DBG; aged ports jump the queue, IF first
  always_comb begin
    gnt_d = P_DBG;
    if (mem_req) begin
      gnt_d = P_MEM;
    end else if (if_req) begin
      gnt_d = P_IF;
    end
`ifdef ARB_AGING_EN
    if (dbg_req && dbg_aged_c) begin
      gnt_d = P_DBG;
    end
    if (if_req && if_aged_c) begin
      gnt_d = P_IF;
    end
`endif
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= P_MEM;
      lat_cnt_q  <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      rsp_rdata  <= '0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      busy       <= 1'b0;
`ifdef ARB_AGING_EN
      if_age_q   <= '0;
      dbg_age_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req_c) begin
            state_q <= S_ISSUE;
            gnt_q   <= gnt_d;
            busy    <= 1'b1;
            bram_en <= 1'b1;
            case (gnt_d)
              P_MEM: begin
                bram_addr  <= mem_addr;
                bram_we    <= mem_we;
                bram_wdata <= mem_wdata;
              end
              P_IF: begin
                bram_addr <= if_addr;
                bram_we   <= 1'b0;
              end
              default: begin
                bram_addr <= dbg_addr;
                bram_we   <= 1'b0;
              end
            endcase
`ifdef ARB_AGING_EN
            if (gnt_d == P_IF) begin
              if_age_q <= '0;
            end else if (if_req && !if_aged_c) begin
              if_age_q <= if_age_q + AGE_W'(1);
            end
            if (gnt_d == P_DBG) begin
              dbg_age_q <= '0;
            end else if (dbg_req && !dbg_aged_c) begin
              dbg_age_q <= dbg_age_q + AGE_W'(1);
            end
`endif
          end
        end

        // bram_we still holds the write flag during the issue cycle
        S_ISSUE: begin
          bram_en   <= 1'b0;
          bram_we   <= 1'b0;
          lat_cnt_q <= '0;
          if (bram_we) begin
            state_q <= S_ACK;
            mem_ack <= (gnt_q == P_MEM);
            if_ack  <= (gnt_q == P_IF);
            dbg_ack <= (gnt_q == P_DBG);
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (lat_cnt_q == CNT_W'(RD_LATENCY - 1)) begin
            rsp_rdata <= bram_rdata;
            state_q   <= S_ACK;
            mem_ack   <= (gnt_q == P_MEM);
            if_ack    <= (gnt_q == P_IF);
            dbg_ack   <= (gnt_q == P_DBG);
          end else begin
            lat_cnt_q <= lat_cnt_q + CNT_W'(1);
          end
        end

        S_ACK: begin
          mem_ack <= 1'b0;
          if_ack  <= 1'b0;
          dbg_ack <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors plus randomized traffic against a transaction model.
// Honours ARB_AGING_EN (AGE_LIMIT forced to 4 when defined).
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned TB_RL = 1;
`ifdef ARB_AGING_EN
  localparam int unsigned TB_AGE = 4;
`endif

  logic          fast_clk;
  logic          rst;
  logic [2:0]    req_v;
  logic [AW-1:0] addr_v [3];
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          if_ack, mem_ack, dbg_ack, bram_en, bram_we, busy;
  logic [DW-1:0] rsp_rdata, bram_wdata, bram_rdata;
  logic [AW-1:0] bram_addr;
  wire  [2:0]    ack_v = {dbg_ack, if_ack, mem_ack};

  int checks;
  int errors;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(TB_RL)
`ifdef ARB_AGING_EN
    , .AGE_LIMIT(TB_AGE)
`endif
  ) dut (
    .fast_clk(fast_clk), .rst(rst),
    .if_req(req_v[1]), .if_addr(addr_v[1]),
    .mem_req(req_v[0]), .mem_we(mem_we), .mem_addr(addr_v[0]), .mem_wdata(mem_wdata),
    .dbg_req(req_v[2]), .dbg_addr(addr_v[2]),
    .if_ack(if_ack), .mem_ack(mem_ack), .dbg_ack(dbg_ack), .rsp_rdata(rsp_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .busy(busy)
  );

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  // BRAM environment: all writes to the array happen in this one block
  logic [DW-1:0] bram [0:1023];
  logic [DW-1:0] rd_pipe [TB_RL];
  logic          init_mem, poke_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  always @(posedge fast_clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) bram[i] <= init_val(i);
    end else if (poke_en) begin
      bram[poke_addr] <= poke_data;
    end else if (bram_en && bram_we) begin
      bram[bram_addr] <= bram_wdata;
    end
    if (bram_en && !bram_we) rd_pipe[0] <= bram[bram_addr];
    for (int i = 1; i < TB_RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[TB_RL-1];

  task automatic tick();
    @(negedge fast_clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // One isolated transaction from an idle arbiter; checks issue cycle, latency, ack and data
  task automatic single(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input string nm);
    int lat;
    logic [2:0] oh;
    lat = 0;
    oh = 3'b001 << p;
    addr_v[p] = a;
    if (p == 0) begin
      mem_we = we;
      mem_wdata = wd;
    end
    req_v[p] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        chk({nm, "_en"}, 64'(bram_en), 64'(1'b1));
        chk({nm, "_addr"}, 64'(bram_addr), 64'(a));
        chk({nm, "_we"}, 64'(bram_we), 64'(we));
        if (we) chk({nm, "_wdata"}, 64'(bram_wdata), 64'(wd));
      end
      if (ack_v != 3'b000) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_lat"}, 64'(lat), 64'(we ? 2 : 2 + TB_RL));
    chk({nm, "_ack"}, 64'(ack_v), 64'(oh));
    chk({nm, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
    req_v[p] = 1'b0;
    mem_we = 1'b0;
    tick();
    chk({nm, "_idle_busy"}, 64'(busy), 64'(1'b0));
    chk({nm, "_idle_ack"}, 64'(ack_v), 64'(3'b000));
  endtask

  typedef struct {
    logic [2:0]    req;
    logic          busy;
    logic          en;
    logic [2:0]    ack;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl [13];

  // Transaction-level reference model state
  logic [DW-1:0] shadow [0:1023];
`ifdef ARB_AGING_EN
  int age_if, age_dbg;
`endif

  function automatic int pick(input logic [2:0] r);
`ifdef ARB_AGING_EN
    if (r[1] && age_if >= int'(TB_AGE)) return 1;
    if (r[2] && age_dbg >= int'(TB_AGE)) return 2;
`endif
    if (r[0]) return 0;
    if (r[1]) return 1;
    if (r[2]) return 2;
    return -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int mem_cnt, dbg_seen;
    int next_idle, iss_cyc, ack_cyc, gp, w;
    logic in_flight, idle_now, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd, g_rd, last_rd;
    logic [2:0] exp_ack;

    // {dbg,if,mem} req | busy | bram_en | {dbg,if,mem} ack | bram_addr
    tbl[0]  = '{3'b111, 1'b0, 1'b0, 3'b000, 10'h000};
    tbl[1]  = '{3'b111, 1'b1, 1'b1, 3'b000, 10'h010};
    tbl[2]  = '{3'b111, 1'b1, 1'b0, 3'b000, 10'h000};
    tbl[3]  = '{3'b110, 1'b1, 1'b0, 3'b001, 10'h000};
    tbl[4]  = '{3'b110, 1'b0, 1'b0, 3'b000, 10'h000};
    tbl[5]  = '{3'b110, 1'b1, 1'b1, 3'b000, 10'h020};
    tbl[6]  = '{3'b110, 1'b1, 1'b0, 3'b000, 10'h000};
    tbl[7]  = '{3'b100, 1'b1, 1'b0, 3'b010, 10'h000};
    tbl[8]  = '{3'b100, 1'b0, 1'b0, 3'b000, 10'h000};
    tbl[9]  = '{3'b100, 1'b1, 1'b1, 3'b000, 10'h030};
    tbl[10] = '{3'b100, 1'b1, 1'b0, 3'b000, 10'h000};
    tbl[11] = '{3'b000, 1'b1, 1'b0, 3'b100, 10'h000};
    tbl[12] = '{3'b000, 1'b0, 1'b0, 3'b000, 10'h000};

    checks = 0;
    errors = 0;
    rst = 1'b1;
    req_v = 3'b000;
    for (int i = 0; i < 3; i++) addr_v[i] = '0;
    mem_we = 1'b0;
    mem_wdata = '0;
    poke_en = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    init_mem = 1'b1;

    repeat (5) tick();
    init_mem = 1'b0;
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_en", 64'(bram_en), 64'(1'b0));
    chk("rst_we", 64'(bram_we), 64'(1'b0));
    chk("rst_ack", 64'(ack_v), 64'(3'b000));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_addr", 64'(bram_addr), 64'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 64'(busy), 64'(1'b0));

    poke_addr = 10'h005;
    poke_data = 32'hDEAD_BEEF;
    poke_en = 1'b1;
    tick();
    poke_en = 1'b0;

    single(1, 1'b0, 10'h005, '0, 32'hDEAD_BEEF, "if_rd");
    single(0, 1'b1, 10'h3FF, 32'h1234_5678, 32'hDEAD_BEEF, "mem_wr");
    single(0, 1'b0, 10'h3FF, '0, 32'h1234_5678, "mem_rd");
    single(2, 1'b0, 10'h005, '0, 32'hDEAD_BEEF, "dbg_rd");

    // Three simultaneous requests, each held until its ack
    addr_v[0] = 10'h010;
    addr_v[1] = 10'h020;
    addr_v[2] = 10'h030;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d_en", i), 64'(bram_en), 64'(tbl[i].en));
      chk($sformatf("tbl%0d_ack", i), 64'(ack_v), 64'(tbl[i].ack));
      if (tbl[i].en) chk($sformatf("tbl%0d_addr", i), 64'(bram_addr), 64'(tbl[i].addr));
      req_v = tbl[i].req;
      tick();
    end

    // Request dropped after one cycle still completes with its ack
    addr_v[1] = 10'h3FF;
    req_v[1] = 1'b1;
    tick();
    chk("viol_en", 64'(bram_en), 64'(1'b1));
    req_v[1] = 1'b0;
    addr_v[1] = 10'h005;
    tick();
    tick();
    chk("viol_ack", 64'(ack_v), 64'(3'b010));
    chk("viol_rdata", 64'(rsp_rdata), 64'(32'h1234_5678));
    tick();
    chk("viol_busy", 64'(busy), 64'(1'b0));

    // Reset during WAIT of an IF read aborts without an ack
    addr_v[1] = 10'h005;
    req_v[1] = 1'b1;
    tick();
    tick();
    chk("rstw_busy_pre", 64'(busy), 64'(1'b1));
    rst = 1'b1;
    req_v[1] = 1'b0;
    #1;
    chk("rstw_busy", 64'(busy), 64'(1'b0));
    chk("rstw_en", 64'(bram_en), 64'(1'b0));
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rstw_noack%0d", k), 64'(ack_v), 64'(3'b000));
      chk($sformatf("rstw_idle%0d", k), 64'(busy), 64'(1'b0));
    end
    single(1, 1'b0, 10'h005, '0, 32'hDEAD_BEEF, "post_rstw");

    // MEM and DBG held continuously
    addr_v[0] = 10'h001;
    addr_v[2] = 10'h002;
    mem_we = 1'b0;
    req_v = 3'b101;
    mem_cnt = 0;
    dbg_seen = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (dbg_seen == 0 && mem_ack) mem_cnt++;
      if (dbg_ack) dbg_seen = 1;
    end
`ifdef ARB_AGING_EN
    chk("starve_dbg_seen", 64'(dbg_seen), 64'(1));
    chk("starve_mem_before_dbg", 64'(mem_cnt), 64'(TB_AGE));
`else
    chk("starve_dbg_seen", 64'(dbg_seen), 64'(0));
    chk("starve_mem_cnt", 64'(mem_cnt), 64'(25));
`endif
    req_v = 3'b000;
    repeat (8) tick();

    // Randomized traffic against the transaction model
    rst = 1'b1;
    init_mem = 1'b1;
    tick();
    init_mem = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
`ifdef ARB_AGING_EN
    age_if = 0;
    age_dbg = 0;
`endif
    last_rd = '0;
    next_idle = 0;
    iss_cyc = -1;
    ack_cyc = -1;
    gp = 0;
    g_we = 1'b0;
    g_addr = '0;
    g_wd = '0;
    g_rd = '0;
    in_flight = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      idle_now = (c >= next_idle);
      chk($sformatf("r_busy@%0d", c), 64'(busy), 64'(!idle_now));
      chk($sformatf("r_en@%0d", c), 64'(bram_en), 64'(c == iss_cyc));
      if (c == iss_cyc) begin
        chk($sformatf("r_addr@%0d", c), 64'(bram_addr), 64'(g_addr));
        chk($sformatf("r_we@%0d", c), 64'(bram_we), 64'(g_we));
        if (g_we) chk($sformatf("r_wdata@%0d", c), 64'(bram_wdata), 64'(g_wd));
      end
      exp_ack = (c == ack_cyc) ? (3'b001 << gp) : 3'b000;
      chk($sformatf("r_ack@%0d", c), 64'(ack_v), 64'(exp_ack));
      if (c == ack_cyc) begin
        if (!g_we) last_rd = g_rd;
        chk($sformatf("r_rdata@%0d", c), 64'(rsp_rdata), 64'(last_rd));
        req_v[gp] = 1'b0;
        in_flight = 1'b0;
      end

      for (int p = 0; p < 3; p++) begin
        if (in_flight && p == gp) begin
          addr_v[p] = AW'($urandom_range(0, 15));
          if (p == 0) begin
            mem_we = 1'($urandom_range(0, 1));
            mem_wdata = $urandom();
          end
        end else if (!req_v[p] && !(c == ack_cyc && p == gp) && $urandom_range(0, 3) == 0) begin
          req_v[p] = 1'b1;
          addr_v[p] = AW'($urandom_range(0, 15));
          if (p == 0) begin
            mem_we = 1'($urandom_range(0, 1));
            mem_wdata = $urandom();
          end
        end
      end

      if (idle_now) begin
        w = pick(req_v);
        if (w < 0) begin
          next_idle = c + 1;
        end else begin
          gp = w;
          g_addr = addr_v[w];
          g_we = (w == 0) && mem_we;
          g_wd = mem_wdata;
          g_rd = shadow[g_addr];
          if (g_we) shadow[g_addr] = g_wd;
          iss_cyc = c + 1;
          ack_cyc = c + 2 + (g_we ? 0 : int'(TB_RL));
          next_idle = ack_cyc + 1;
          in_flight = 1'b1;
`ifdef ARB_AGING_EN
          if (w == 1) age_if = 0;
          else if (req_v[1] && age_if < int'(TB_AGE)) age_if++;
          if (w == 2) age_dbg = 0;
          else if (req_v[2] && age_dbg < int'(TB_AGE)) age_dbg++;
`endif
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
